// File: rtl/s3_axi_write_slave.sv
// ---------------------------------------------------------------------------
// s3_axi_write_slave
//
// AXI write-path endpoint sitting on crossbar slave port 3. Accepts one write
// burst at a time (AW, then W beats, then a B response) and stores the data
// into an internal word memory. A combinational backdoor port exposes any
// memory word for inspection.
//
// Ports
//   ACLK, ARESET        clock, synchronous active-high reset
//   S3_AW*              write address channel (ID, address, LEN, SIZE, BURST)
//   S3_W*               write data channel (data, strobes, last, handshake)
//   S3_B*               write response channel (ID, response, handshake)
//   dbg_addr/dbg_rdata  backdoor word read of the memory
//
// Optional feature
//   S3_WR_STALL_EN      when defined, WREADY drops for STALL_CYCLES cycles
//                       after every accepted non-final W beat.
// ---------------------------------------------------------------------------
module s3_axi_write_slave #(
    parameter int                    ID_WIDTH     = 4,
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEM_DEPTH    = 256,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0003_0000,
    parameter int                    STALL_CYCLES = 2
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ID_WIDTH-1:0]          S3_AWID,
    input  logic [ADDR_WIDTH-1:0]        S3_AWADDR,
    input  logic [3:0]                   S3_AWLEN,
    input  logic [2:0]                   S3_AWSIZE,
    input  logic [1:0]                   S3_AWBURST,
    input  logic                         S3_AWVALID,
    output logic                         S3_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S3_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S3_WSTRB,
    input  logic                         S3_WLAST,
    input  logic                         S3_WVALID,
    output logic                         S3_WREADY,
    output logic [ID_WIDTH-1:0]          S3_BID,
    output logic [1:0]                   S3_BRESP,
    output logic                         S3_BVALID,
    input  logic                         S3_BREADY,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_rdata
);

    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int NBYTES = DATA_WIDTH / 8;

    // Decode window computed one bit wider so BASE+size never overflows.
    localparam logic [ADDR_WIDTH:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDR_WIDTH:0] LIMIT_EXT = BASE_EXT + (ADDR_WIDTH+1)'(4 * MEM_DEPTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ID_WIDTH-1:0] r_id;
    logic [3:0]          r_len;
    logic [IDX_W-1:0]    r_idx;
    logic                r_fixed;
    logic [1:0]          r_awErr;
    logic [4:0]          r_beatCnt;
    logic [1:0]          r_bresp;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_awready;
    logic                  w_wready;
    logic                  w_bvalid;
    logic                  w_awHs;
    logic                  w_wHs;
    logic                  w_inLen;
    logic                  w_doWrite;
    logic                  w_stallDone;
    logic [ADDR_WIDTH:0]   w_addrExt;
    logic [ADDR_WIDTH-1:0] w_offset;
    logic                  w_decErr;
    logic                  w_slvErr;
    logic [1:0]            w_awErr;
    logic                  w_unusedOffset;

    // Address-phase error classification; DECERR outranks the SLVERR cases.
    assign w_addrExt      = {1'b0, S3_AWADDR};
    assign w_decErr       = (w_addrExt < BASE_EXT) || (w_addrExt >= LIMIT_EXT);
    assign w_slvErr       = S3_AWBURST[1] || (S3_AWSIZE != 3'd2) || (S3_AWADDR[1:0] != 2'b00);
    assign w_awErr        = w_decErr ? RESP_DECERR : (w_slvErr ? RESP_SLVERR : RESP_OKAY);
    assign w_offset       = S3_AWADDR - BASE_ADDR;
    assign w_unusedOffset = ^{w_offset[ADDR_WIDTH-1:IDX_W+2], w_offset[1:0]};

    assign w_awHs    = w_awready && S3_AWVALID;
    assign w_wHs     = w_wready && S3_WVALID;
    // Beats beyond LEN (late WLAST) are accepted but never written.
    assign w_inLen   = r_beatCnt <= {1'b0, r_len};
    assign w_doWrite = w_wHs && (r_awErr == RESP_OKAY) && w_inLen && !ARESET;

`ifdef S3_WR_STALL_EN
    localparam int STALL_W = (STALL_CYCLES < 1) ? 1 : $clog2(STALL_CYCLES + 1);
    logic [STALL_W-1:0] r_stall;

    // Stall counter reloads on every non-final beat and counts down to zero;
    // WREADY is only offered while it sits at zero.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_stall <= '0;
        end else if (w_awHs) begin
            r_stall <= '0;
        end else if (w_wHs && !S3_WLAST) begin
            r_stall <= STALL_W'(STALL_CYCLES);
        end else if (r_stall != '0) begin
            r_stall <= r_stall - STALL_W'(1);
        end
    end

    assign w_stallDone = (r_stall == '0);
`else
    assign w_stallDone = 1'b1;
`endif

    // Next-state and handshake outputs. AWREADY is also masked by ARESET so
    // it reads low throughout a reset cycle.
    always_comb begin
        w_next    = r_state;
        w_awready = 1'b0;
        w_wready  = 1'b0;
        w_bvalid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_awready = !ARESET;
                if (S3_AWVALID && !ARESET) begin
                    w_next = DATA;
                end
            end
            DATA: begin
                w_wready = w_stallDone;
                if (w_stallDone && S3_WVALID && S3_WLAST) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                w_bvalid = 1'b1;
                if (S3_BREADY) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register plus burst context captured at the AW handshake and
    // advanced on each W beat. The response code is resolved on the WLAST beat.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state   <= IDLE;
            r_id      <= '0;
            r_len     <= '0;
            r_idx     <= '0;
            r_fixed   <= 1'b0;
            r_awErr   <= RESP_OKAY;
            r_beatCnt <= '0;
            r_bresp   <= RESP_OKAY;
        end else begin
            r_state <= w_next;
            if (w_awHs) begin
                r_id      <= S3_AWID;
                r_len     <= S3_AWLEN;
                r_idx     <= w_offset[IDX_W+1:2];
                r_fixed   <= (S3_AWBURST == 2'b00);
                r_awErr   <= w_awErr;
                r_beatCnt <= '0;
            end
            if (w_wHs) begin
                if (w_inLen) begin
                    r_beatCnt <= r_beatCnt + 5'd1;
                end
                if (!r_fixed) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
                if (S3_WLAST) begin
                    if (r_awErr != RESP_OKAY) begin
                        r_bresp <= r_awErr;
                    end else if (r_beatCnt != {1'b0, r_len}) begin
                        r_bresp <= RESP_SLVERR;
                    end else begin
                        r_bresp <= RESP_OKAY;
                    end
                end
            end
        end
    end

    // Byte-lane memory write; contents deliberately survive reset.
    always_ff @(posedge ACLK) begin
        if (w_doWrite) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (S3_WSTRB[b]) begin
                    r_mem[r_idx][8*b +: 8] <= S3_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign S3_AWREADY = w_awready;
    assign S3_WREADY  = w_wready;
    assign S3_BVALID  = w_bvalid;
    assign S3_BID     = r_id;
    assign S3_BRESP   = r_bresp;
    assign dbg_rdata  = r_mem[dbg_addr];

endmodule

// File: tb/tb_s3_axi_write_slave.sv
// ---------------------------------------------------------------------------
// tb_s3_axi_write_slave
//
// Directed bench for s3_axi_write_slave: drives AW/W bursts, completes the B
// handshake and inspects memory via the backdoor port. Expected values are
// hand-computed constants. Define S3_WR_STALL_EN to add the WREADY stall
// pattern step.
// ---------------------------------------------------------------------------
module tb_s3_axi_write_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S3_AWID;
    logic [31:0] S3_AWADDR;
    logic [3:0]  S3_AWLEN;
    logic [2:0]  S3_AWSIZE;
    logic [1:0]  S3_AWBURST;
    logic        S3_AWVALID;
    logic        S3_AWREADY;
    logic [31:0] S3_WDATA;
    logic [3:0]  S3_WSTRB;
    logic        S3_WLAST;
    logic        S3_WVALID;
    logic        S3_WREADY;
    logic [3:0]  S3_BID;
    logic [1:0]  S3_BRESP;
    logic        S3_BVALID;
    logic        S3_BREADY;
    logic [7:0]  dbg_addr;
    logic [31:0] dbg_rdata;

    int tests  = 0;
    int failed = 0;

    s3_axi_write_slave dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .S3_AWID    (S3_AWID),
        .S3_AWADDR  (S3_AWADDR),
        .S3_AWLEN   (S3_AWLEN),
        .S3_AWSIZE  (S3_AWSIZE),
        .S3_AWBURST (S3_AWBURST),
        .S3_AWVALID (S3_AWVALID),
        .S3_AWREADY (S3_AWREADY),
        .S3_WDATA   (S3_WDATA),
        .S3_WSTRB   (S3_WSTRB),
        .S3_WLAST   (S3_WLAST),
        .S3_WVALID  (S3_WVALID),
        .S3_WREADY  (S3_WREADY),
        .S3_BID     (S3_BID),
        .S3_BRESP   (S3_BRESP),
        .S3_BVALID  (S3_BVALID),
        .S3_BREADY  (S3_BREADY),
        .dbg_addr   (dbg_addr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 ACLK = ~ACLK;

    // Safety net in case a handshake bound is somehow bypassed.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one AW transfer and wait (bounded) for the handshake edge.
    task automatic applyStimulus(input logic [3:0] id, input logic [31:0] addr,
                                 input logic [3:0] len, input logic [2:0] size,
                                 input logic [1:0] burst);
        logic hs;
        S3_AWID    = id;
        S3_AWADDR  = addr;
        S3_AWLEN   = len;
        S3_AWSIZE  = size;
        S3_AWBURST = burst;
        S3_AWVALID = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = S3_AWREADY;
            @(posedge ACLK); #1;
        end
        S3_AWVALID = 1'b0;
        checkOutput("aw_handshake", 32'(hs), 32'd1);
    endtask

    // Present one W beat and wait (bounded) for it to be accepted.
    task automatic applyBeat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        logic hs;
        S3_WDATA  = data;
        S3_WSTRB  = strb;
        S3_WLAST  = last;
        S3_WVALID = 1'b1;
        hs = 1'b0;
        for (int i = 0; i < 20 && !hs; i++) begin
            hs = S3_WREADY;
            @(posedge ACLK); #1;
        end
        S3_WVALID = 1'b0;
        S3_WLAST  = 1'b0;
        checkOutput("w_handshake", 32'(hs), 32'd1);
    endtask

    // Called right after the final beat: B must already be valid. Optionally
    // withholds BREADY (with a competing AW) to check hold-stability.
    task automatic checkResp(input logic [3:0] id, input logic [1:0] resp, input int hold);
        checkOutput("b_valid", 32'(S3_BVALID), 32'd1);
        checkOutput("b_id", 32'(S3_BID), 32'(id));
        checkOutput("b_resp", 32'(S3_BRESP), 32'(resp));
        checkOutput("b_wready_low", 32'(S3_WREADY), 32'd0);
        if (hold > 0) begin
            S3_AWADDR  = 32'h0003_0100;
            S3_AWVALID = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge ACLK); #1;
            checkOutput("hold_bvalid", 32'(S3_BVALID), 32'd1);
            checkOutput("hold_bid", 32'(S3_BID), 32'(id));
            checkOutput("hold_bresp", 32'(S3_BRESP), 32'(resp));
            checkOutput("hold_awready", 32'(S3_AWREADY), 32'd0);
        end
        S3_AWVALID = 1'b0;
        S3_BREADY  = 1'b1;
        @(posedge ACLK); #1;
        S3_BREADY  = 1'b0;
        checkOutput("b_done_bvalid", 32'(S3_BVALID), 32'd0);
        checkOutput("b_done_awready", 32'(S3_AWREADY), 32'd1);
    endtask

    task automatic checkMem(input string tag, input logic [7:0] idx, input logic [31:0] exp);
        dbg_addr = idx;
        @(negedge ACLK);
        checkOutput(tag, dbg_rdata, exp);
    endtask

    initial begin
        ARESET     = 1'b1;
        S3_AWID    = '0;
        S3_AWADDR  = '0;
        S3_AWLEN   = '0;
        S3_AWSIZE  = '0;
        S3_AWBURST = '0;
        S3_AWVALID = 1'b0;
        S3_WDATA   = '0;
        S3_WSTRB   = '0;
        S3_WLAST   = 1'b0;
        S3_WVALID  = 1'b0;
        S3_BREADY  = 1'b0;
        dbg_addr   = '0;

        // Reset state
        @(posedge ACLK); @(posedge ACLK); #1;
        checkOutput("rst_awready", 32'(S3_AWREADY), 32'd0);
        checkOutput("rst_wready", 32'(S3_WREADY), 32'd0);
        checkOutput("rst_bvalid", 32'(S3_BVALID), 32'd0);
        checkOutput("rst_bid", 32'(S3_BID), 32'd0);
        checkOutput("rst_bresp", 32'(S3_BRESP), 32'd0);
        ARESET = 1'b0;
        @(posedge ACLK); #1;
        checkOutput("idle_awready", 32'(S3_AWREADY), 32'd1);

        // INCR burst of 4 at word 4
        applyStimulus(4'd5, 32'h0003_0010, 4'd3, 3'd2, 2'b01);
        checkOutput("t1_wready", 32'(S3_WREADY), 32'd1);
        checkOutput("t1_awready_data", 32'(S3_AWREADY), 32'd0);
        applyBeat(32'h11, 4'hF, 1'b0);
        applyBeat(32'h22, 4'hF, 1'b0);
        applyBeat(32'h33, 4'hF, 1'b0);
        applyBeat(32'h44, 4'hF, 1'b1);
        checkResp(4'd5, 2'b00, 0);
        checkMem("t1_mem4", 8'd4, 32'h11);
        checkMem("t1_mem5", 8'd5, 32'h22);
        checkMem("t1_mem6", 8'd6, 32'h33);
        checkMem("t1_mem7", 8'd7, 32'h44);

        // FIXED burst: only the last beat survives at word 8
        applyStimulus(4'd2, 32'h0003_0020, 4'd2, 3'd2, 2'b00);
        applyBeat(32'hA, 4'hF, 1'b0);
        applyBeat(32'hB, 4'hF, 1'b0);
        applyBeat(32'hC, 4'hF, 1'b1);
        checkResp(4'd2, 2'b00, 0);
        checkMem("fixed_mem8", 8'd8, 32'hC);

        // Known value at word 0 for the suppression checks below
        applyStimulus(4'd1, 32'h0003_0000, 4'd0, 3'd2, 2'b01);
        applyBeat(32'hCAFE_F00D, 4'hF, 1'b1);
        checkResp(4'd1, 2'b00, 0);
        checkMem("base_mem0", 8'd0, 32'hCAFE_F00D);

        // Address-phase errors: nothing written
        applyStimulus(4'd3, 32'h0004_0000, 4'd0, 3'd2, 2'b01);
        applyBeat(32'hDEAD_0001, 4'hF, 1'b1);
        checkResp(4'd3, 2'b11, 0);
        applyStimulus(4'd4, 32'h0003_0000, 4'd0, 3'd2, 2'b10);
        applyBeat(32'hDEAD_0002, 4'hF, 1'b1);
        checkResp(4'd4, 2'b10, 0);
        applyStimulus(4'd6, 32'h0003_0000, 4'd0, 3'd1, 2'b01);
        applyBeat(32'hDEAD_0003, 4'hF, 1'b1);
        checkResp(4'd6, 2'b10, 0);
        applyStimulus(4'd7, 32'h0003_0002, 4'd0, 3'd2, 2'b01);
        applyBeat(32'hDEAD_0004, 4'hF, 1'b1);
        checkResp(4'd7, 2'b10, 0);
        applyStimulus(4'd8, 32'h0002_FFFC, 4'd0, 3'd2, 2'b01);
        applyBeat(32'hDEAD_0005, 4'hF, 1'b1);
        checkResp(4'd8, 2'b11, 0);
        applyStimulus(4'd9, 32'h0003_0400, 4'd0, 3'd2, 2'b01);
        applyBeat(32'hDEAD_0006, 4'hF, 1'b1);
        checkResp(4'd9, 2'b11, 0);
        checkMem("err_mem0_kept", 8'd0, 32'hCAFE_F00D);

        // Last in-range word: INCR wraps to word 0 without error
        applyStimulus(4'd8, 32'h0003_03FC, 4'd1, 3'd2, 2'b01);
        applyBeat(32'h77, 4'hF, 1'b0);
        applyBeat(32'h88, 4'hF, 1'b1);
        checkResp(4'd8, 2'b00, 0);
        checkMem("wrap_mem255", 8'd255, 32'h77);
        checkMem("wrap_mem0", 8'd0, 32'h88);

        // Seed word 18, then early WLAST at word 16 with BREADY withheld
        applyStimulus(4'd9, 32'h0003_0048, 4'd1, 3'd2, 2'b01);
        applyBeat(32'h99, 4'hF, 1'b0);
        applyBeat(32'h98, 4'hF, 1'b1);
        checkResp(4'd9, 2'b00, 0);
        applyStimulus(4'd10, 32'h0003_0040, 4'd3, 3'd2, 2'b01);
        applyBeat(32'hA1, 4'hF, 1'b0);
        applyBeat(32'hA2, 4'hF, 1'b1);
        checkResp(4'd10, 2'b10, 5);
        checkMem("early_mem16", 8'd16, 32'hA1);
        checkMem("early_mem17", 8'd17, 32'hA2);
        checkMem("early_mem18", 8'd18, 32'h99);

        // Late WLAST: first beat written, extra beat dropped
        applyStimulus(4'd11, 32'h0003_0050, 4'd0, 3'd2, 2'b01);
        applyBeat(32'h61, 4'hF, 1'b0);
        applyBeat(32'h62, 4'hF, 1'b1);
        checkResp(4'd11, 2'b10, 0);
        checkMem("late_mem20", 8'd20, 32'h61);

        // Byte strobes on a FIXED burst, then an all-zero strobe beat
        applyStimulus(4'd12, 32'h0003_0060, 4'd1, 3'd2, 2'b00);
        applyBeat(32'hAABB_CCDD, 4'hF, 1'b0);
        applyBeat(32'h1122_3344, 4'b0101, 1'b1);
        checkResp(4'd12, 2'b00, 0);
        checkMem("strb_mem24", 8'd24, 32'hAA22_CC44);
        applyStimulus(4'd13, 32'h0003_0060, 4'd0, 3'd2, 2'b01);
        applyBeat(32'hFFFF_FFFF, 4'h0, 1'b1);
        checkResp(4'd13, 2'b00, 0);
        checkMem("strb0_mem24", 8'd24, 32'hAA22_CC44);

        // Reset mid-burst: abandoned, committed beats remain
        applyStimulus(4'd14, 32'h0003_0080, 4'd3, 3'd2, 2'b01);
        applyBeat(32'h1, 4'hF, 1'b0);
        applyBeat(32'h2, 4'hF, 1'b0);
        ARESET = 1'b1;
        #1;
        checkOutput("midrst_awready_low", 32'(S3_AWREADY), 32'd0);
        @(posedge ACLK); #1;
        ARESET = 1'b0;
        #1;
        checkOutput("midrst_awready", 32'(S3_AWREADY), 32'd1);
        checkOutput("midrst_wready", 32'(S3_WREADY), 32'd0);
        checkOutput("midrst_bvalid", 32'(S3_BVALID), 32'd0);
        checkMem("midrst_mem32", 8'd32, 32'h1);
        checkMem("midrst_mem33", 8'd33, 32'h2);
        applyStimulus(4'd15, 32'h0003_0088, 4'd0, 3'd2, 2'b01);
        applyBeat(32'h5A, 4'hF, 1'b1);
        checkResp(4'd15, 2'b00, 0);
        checkMem("postrst_mem34", 8'd34, 32'h5A);

`ifdef S3_WR_STALL_EN
        // Continuous WVALID over a 3-beat burst: WREADY 1,0,0,1,0,0,1
        begin
            logic [6:0] pat;
            int beats;
            pat   = '0;
            beats = 0;
            applyStimulus(4'd1, 32'h0003_00C0, 4'd2, 3'd2, 2'b01);
            S3_WVALID = 1'b1;
            S3_WSTRB  = 4'hF;
            for (int i = 0; i < 7; i++) begin
                S3_WDATA = 32'(beats + 1);
                S3_WLAST = (beats == 2);
                pat = {pat[5:0], S3_WREADY};
                @(posedge ACLK); #1;
                if (pat[0]) beats++;
            end
            S3_WVALID = 1'b0;
            S3_WLAST  = 1'b0;
            checkOutput("stall_pattern", 32'(pat), 32'b1001001);
            checkResp(4'd1, 2'b00, 0);
            checkMem("stall_mem50", 8'd50, 32'h3);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
